// File: rtl/wgp_pkg.sv
// Shared widths, constants and sample types for the waveform generator.
package wgp_pkg;

    localparam int unsigned PHASE_W     = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned QUARTER_LEN = 65;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [DATA_W-1:0]  sample_t;

    localparam sample_t MIDSCALE = 8'd128;

endpackage

// File: rtl/wgp_sine_lut.sv
// Combinational offset-binary sine: 65-entry quarter-wave table plus quadrant folding.
module wgp_sine_lut
    import wgp_pkg::*;
(
    input  logic [PHASE_W-1:0] p,
    output sample_t            sin
);

    // round(127 * sin(2*pi*i/256)), i = 0..64
    localparam logic [6:0] QTAB [QUARTER_LEN] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    logic [1:0] quad;
    logic [5:0] q;
    logic [6:0] idx;
    logic [6:0] mag;

    always_comb begin
        quad = p[7:6];
        q    = p[5:0];
        // Odd quadrants read the table backwards; index 64 is reachable only there.
        idx  = quad[0] ? (7'd64 - {1'b0, q}) : {1'b0, q};
        mag  = QTAB[idx];
        sin  = quad[1] ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});
    end

endmodule

// File: rtl/waveform_generator_processor.sv
// Six phase-aligned waveforms from an 8-bit phase index, one registered clock of latency.
// Define WGP_RECIPROCAL_EN to build the reciprocal divider; otherwise that output is tied to 0.
module waveform_generator_processor
    import wgp_pkg::*;
#(
    parameter logic [7:0] SQUARE_DUTY = 8'd128
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] count_num,
    output sample_t            waveform_square,
    output sample_t            waveform_reciprocal,
    output sample_t            waveform_triangle,
    output sample_t            waveform_sin,
    output sample_t            waveform_full_wave_rectified,
    output sample_t            waveform_half_wave_rectified
);

    sample_t    sin_val;
    logic       sin_pos;
    logic [8:0] tri_w;
    logic [8:0] mag_w;
    logic [8:0] full_w;
    logic [8:0] half_w;
    sample_t    square_next;

    wgp_sine_lut u_sine_lut (
        .p   (count_num),
        .sin (sin_val)
    );

    always_comb begin
        square_next = (count_num < SQUARE_DUTY) ? 8'hFF : 8'h00;
        tri_w = count_num[7] ? ((9'd255 - {1'b0, count_num}) << 1)
                             : ({1'b0, count_num} << 1);
        // Rectifiers share the same-cycle sine so every output stays phase-aligned.
        sin_pos = (sin_val >= MIDSCALE);
        mag_w   = sin_pos ? ({1'b0, sin_val} - {1'b0, MIDSCALE})
                          : ({1'b0, MIDSCALE} - {1'b0, sin_val});
        full_w  = mag_w << 1;
        half_w  = sin_pos ? full_w : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waveform_square              <= '0;
            waveform_triangle            <= '0;
            waveform_sin                 <= '0;
            waveform_full_wave_rectified <= '0;
            waveform_half_wave_rectified <= '0;
        end else begin
            waveform_square              <= square_next;
            waveform_triangle            <= sample_t'(tri_w);
            waveform_sin                 <= sin_val;
            waveform_full_wave_rectified <= sample_t'(full_w);
            waveform_half_wave_rectified <= sample_t'(half_w);
        end
    end

`ifdef WGP_RECIPROCAL_EN
    sample_t recip_next;

    always_comb begin
        recip_next = sample_t'(9'd255 / ({1'b0, count_num} + 9'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waveform_reciprocal <= '0;
        end else begin
            waveform_reciprocal <= recip_next;
        end
    end
`else
    assign waveform_reciprocal = '0;
`endif

endmodule

// File: tb/tb_waveform_generator_processor.sv
// Scoreboard bench: driver queues expected outputs per applied phase, monitor pops one per clock.
module tb_waveform_generator_processor;

    typedef struct {
        logic [7:0] sq;
        logic [7:0] rc;
        logic [7:0] tr;
        logic [7:0] sn;
        logic [7:0] fw;
        logic [7:0] hw;
        int         id;
    } exp_t;

    localparam real PI = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] count_num = 8'd0;
    logic [7:0] waveform_square;
    logic [7:0] waveform_reciprocal;
    logic [7:0] waveform_triangle;
    logic [7:0] waveform_sin;
    logic [7:0] waveform_full_wave_rectified;
    logic [7:0] waveform_half_wave_rectified;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   next_id     = 0;

    always #5 clk = ~clk;

    waveform_generator_processor #(.SQUARE_DUTY(8'd128)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .count_num                    (count_num),
        .waveform_square              (waveform_square),
        .waveform_reciprocal          (waveform_reciprocal),
        .waveform_triangle            (waveform_triangle),
        .waveform_sin                 (waveform_sin),
        .waveform_full_wave_rectified (waveform_full_wave_rectified),
        .waveform_half_wave_rectified (waveform_half_wave_rectified)
    );

    function automatic exp_t mk(input logic [7:0] sq, input logic [7:0] rc, input logic [7:0] tr,
                                input logic [7:0] sn, input logic [7:0] fw, input logic [7:0] hw);
        exp_t e;
        e.sq = sq;
`ifdef WGP_RECIPROCAL_EN
        e.rc = rc;
`else
        e.rc = 8'd0;
`endif
        e.tr = tr; e.sn = sn; e.fw = fw; e.hw = hw; e.id = 0;
        return e;
    endfunction

    // Golden model from the closed-form sine, independent of any table.
    function automatic exp_t model(input int p);
        real  x;
        int   s;
        int   rnd;
        int   rc;
        int   tr;
        x   = 127.0 * $sin(2.0 * PI * p / 256.0);
        rnd = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        s   = 128 + rnd;
        rc  = 255 / (p + 1);
        tr  = (p < 128) ? 2 * p : 2 * (255 - p);
        return mk((p < 128) ? 8'hFF : 8'h00, 8'(rc), 8'(tr), 8'(s),
                  8'((s >= 128) ? 2 * (s - 128) : 2 * (128 - s)),
                  8'((s >= 128) ? 2 * (s - 128) : 0));
    endfunction

    task automatic apply(input int p, input logic r, input exp_t e);
        exp_t t;
        @(negedge clk);
        count_num = 8'(p);
        rst       = r;
        t         = e;
        t.id      = next_id;
        next_id++;
        sb.push_back(t);
    endtask

    task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                check("square",     e.id, waveform_square,              e.sq);
                check("reciprocal", e.id, waveform_reciprocal,          e.rc);
                check("triangle",   e.id, waveform_triangle,            e.tr);
                check("sin",        e.id, waveform_sin,                 e.sn);
                check("full_wave",  e.id, waveform_full_wave_rectified, e.fw);
                check("half_wave",  e.id, waveform_half_wave_rectified, e.hw);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        exp_t zero;
        zero = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        // Reset with a non-zero phase on the input
        apply(77, 1'b1, zero);

        // Hand-computed corner phases
        apply(0,   1'b0, mk(8'hFF, 8'd255, 8'd0,   8'd128, 8'd0,   8'd0));
        apply(1,   1'b0, mk(8'hFF, 8'd127, 8'd2,   8'd131, 8'd6,   8'd6));
        apply(64,  1'b0, mk(8'hFF, 8'd3,   8'd128, 8'd255, 8'd254, 8'd254));
        apply(127, 1'b0, mk(8'hFF, 8'd1,   8'd254, 8'd131, 8'd6,   8'd6));
        apply(128, 1'b0, mk(8'h00, 8'd1,   8'd254, 8'd128, 8'd0,   8'd0));
        apply(192, 1'b0, mk(8'h00, 8'd1,   8'd126, 8'd1,   8'd254, 8'd0));
        apply(254, 1'b0, mk(8'h00, 8'd1,   8'd2,   8'd122, 8'd12,  8'd0));
        apply(255, 1'b0, mk(8'h00, 8'd0,   8'd0,   8'd125, 8'd6,   8'd0));
        apply(0,   1'b0, mk(8'hFF, 8'd255, 8'd0,   8'd128, 8'd0,   8'd0));

        // Ten continuous periods through the 255 -> 0 wrap
        for (int k = 0; k < 10; k++) begin
            for (int p = 0; p < 256; p++) begin
                apply(p, 1'b0, model(p));
            end
        end

        // Reset for one edge mid-sweep, then normal values resume
        for (int p = 0; p < 256; p++) begin
            if (p == 100) apply(p, 1'b1, zero);
            else          apply(p, 1'b0, model(p));
        end

        // Random phases, one clock each
        for (int i = 0; i < 300; i++) begin
            int p;
            p = int'($urandom_range(0, 255));
            apply(p, 1'b0, model(p));
        end

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
